// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: a byte-addressed, little-endian instruction store
// with a word write port for program loading and an internal next-PC register.
// Each cycle it fetches sequentially, stalls or redirects on a branch.
// Misaligned and out-of-range fetches park the unit in FAULT until a branch
// arrives.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH_BYTES = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   Stall,
    input  logic                   BranchTaken,
    input  logic [ADDR_WIDTH-1:0]  BranchTarget,
    input  logic                   WrEn,
    input  logic [ADDR_WIDTH-1:0]  WrAddr,
    input  logic [INSTR_WIDTH-1:0] WrData,
    output logic [INSTR_WIDTH-1:0] Instruction,
    output logic [ADDR_WIDTH-1:0]  InstrPC,
    output logic                   InstrValid,
    output logic                   Fault,
    output logic [1:0]             FaultCode
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int MEM_W = DEPTH_BYTES * 8;
    // Highest byte address at which a whole word still fits.
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } state_t;

    // Power-up image: every byte holds its own address modulo 256.
    function automatic logic [MEM_W-1:0] init_mem();
        logic [MEM_W-1:0] v;
        v = '0;
        for (int i = 0; i < DEPTH_BYTES; i++) begin
            v[i*8 +: 8] = 8'(i);
        end
        return v;
    endfunction

    // Byte i lives at bits [8i+7:8i], so a word slice is already little-endian.
    logic [MEM_W-1:0]       mem_r = init_mem();

    state_t                 state_r;
    state_t                 state_s;
    logic [ADDR_WIDTH-1:0]  npc_r;
    logic [ADDR_WIDTH-1:0]  npc_s;
    logic [INSTR_WIDTH-1:0] instr_s;
    logic [ADDR_WIDTH-1:0]  pc_s;
    logic                   valid_s;
    logic                   fault_s;
    logic [1:0]             code_s;

    logic [IDX_W-3:0]       rd_word_s;
    logic [IDX_W-3:0]       wr_word_s;
    logic [INSTR_WIDTH-1:0] rd_data_s;
    logic                   wr_ok_s;
    logic                   misaligned_s;
    logic                   out_of_range_s;

    assign rd_word_s      = npc_r[IDX_W-1:2];
    assign wr_word_s      = WrAddr[IDX_W-1:2];
    assign rd_data_s      = mem_r[{rd_word_s, 5'b00000} +: INSTR_WIDTH];
    assign misaligned_s   = (npc_r[1:0] != 2'b00);
    assign out_of_range_s = (npc_r > LAST_WORD);
    // The range check also rejects addresses that would alias onto low words.
    assign wr_ok_s        = WrEn && (WrAddr[1:0] == 2'b00) && (WrAddr <= LAST_WORD);

    // Program-load write port; a write sampled while reset is low is dropped.
    always_ff @(posedge clk) begin
        if (reset_n && wr_ok_s) begin
            mem_r[{wr_word_s, 5'b00000} +: INSTR_WIDTH] <= WrData;
        end
    end

    // State, next-PC and registered output update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            npc_r       <= RESET_PC;
            Instruction <= '0;
            InstrPC     <= '0;
            InstrValid  <= 1'b0;
            Fault       <= 1'b0;
            FaultCode   <= 2'b00;
        end else begin
            state_r     <= state_s;
            npc_r       <= npc_s;
            Instruction <= instr_s;
            InstrPC     <= pc_s;
            InstrValid  <= valid_s;
            Fault       <= fault_s;
            FaultCode   <= code_s;
        end
    end

    // Next-state and next-output decision; everything holds unless changed.
    always_comb begin
        state_s = state_r;
        npc_s   = npc_r;
        instr_s = Instruction;
        pc_s    = InstrPC;
        valid_s = InstrValid;
        fault_s = Fault;
        code_s  = FaultCode;
        case (state_r)
            IDLE: begin
                state_s = RUN;
            end
            RUN: begin
                if (BranchTaken) begin
                    npc_s   = BranchTarget;
                    valid_s = 1'b0;
                end else if (Stall) begin
                    valid_s = InstrValid;
                end else if (misaligned_s || out_of_range_s) begin
                    valid_s = 1'b0;
                    fault_s = 1'b1;
                    code_s  = misaligned_s ? 2'b01 : 2'b10;
                    state_s = FAULT;
                end else begin
                    instr_s = rd_data_s;
                    pc_s    = npc_r;
                    valid_s = 1'b1;
                    npc_s   = npc_r + ADDR_WIDTH'(4);
                end
            end
            FAULT: begin
                if (BranchTaken) begin
                    npc_s   = BranchTarget;
                    fault_s = 1'b0;
                    code_s  = 2'b00;
                    valid_s = 1'b0;
                    state_s = RUN;
                end else begin
                    valid_s = 1'b0;
                end
            end
            default: begin
                // Unreachable encoding: recover through IDLE with outputs quiet.
                state_s = IDLE;
                npc_s   = RESET_PC;
                valid_s = 1'b0;
                fault_s = 1'b0;
                code_s  = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit (default parameters, 64-byte store).
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        Stall;
    logic        BranchTaken;
    logic [63:0] BranchTarget;
    logic        WrEn;
    logic [63:0] WrAddr;
    logic [31:0] WrData;
    logic [31:0] Instruction;
    logic [63:0] InstrPC;
    logic        InstrValid;
    logic        Fault;
    logic [1:0]  FaultCode;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .WrEn         (WrEn),
        .WrAddr       (WrAddr),
        .WrData       (WrData),
        .Instruction  (Instruction),
        .InstrPC      (InstrPC),
        .InstrValid   (InstrValid),
        .Fault        (Fault),
        .FaultCode    (FaultCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input string tag, input logic [63:0] pc, input logic [31:0] ins);
        check({tag, "_valid"}, 64'(InstrValid), 64'd1);
        check({tag, "_pc"}, InstrPC, pc);
        check({tag, "_instr"}, 64'(Instruction), 64'(ins));
        check({tag, "_fault"}, 64'(Fault), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 64'd0;
        WrEn = 1'b0; WrAddr = 64'd0; WrData = 32'd0;
        step(); step();
        check("rst_instr", 64'(Instruction), 64'd0);
        check("rst_pc", InstrPC, 64'd0);
        check("rst_valid", 64'(InstrValid), 64'd0);
        check("rst_fault", 64'(Fault), 64'd0);
        check("rst_code", 64'(FaultCode), 64'd0);

        // Release: edge 1 IDLE->RUN, edges 2..5 fetch 0,4,8,12 (with a stall at PC 4).
        reset_n = 1'b1;
        step();
        check("idle_valid", 64'(InstrValid), 64'd0);
        step(); expect_fetch("seq0", 64'h0, 32'h03020100);
        step(); expect_fetch("seq4", 64'h4, 32'h07060504);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); expect_fetch("stall4", 64'h4, 32'h07060504);
        end
        Stall = 1'b0;
        step(); expect_fetch("seq8", 64'h8, 32'h0B0A0908);
        step(); expect_fetch("seq12", 64'hC, 32'h0F0E0D0C);

        // Branch with simultaneous stall: branch wins.
        BranchTaken = 1'b1; BranchTarget = 64'h20; Stall = 1'b1;
        step();
        check("br20_bubble", 64'(InstrValid), 64'd0);
        BranchTaken = 1'b0; Stall = 1'b0;
        step(); expect_fetch("br20", 64'h20, 32'h23222120);
        step(); expect_fetch("br24", 64'h24, 32'h27262524);

        // Misaligned branch target faults and holds through stalls.
        BranchTaken = 1'b1; BranchTarget = 64'h22;
        step();
        check("br22_bubble", 64'(InstrValid), 64'd0);
        BranchTaken = 1'b0;
        step();
        check("mis_fault", 64'(Fault), 64'd1);
        check("mis_code", 64'(FaultCode), 64'd1);
        check("mis_valid", 64'(InstrValid), 64'd0);
        Stall = 1'b1; step();
        check("mis_hold_stall", 64'(Fault), 64'd1);
        Stall = 1'b0; step();
        check("mis_hold", 64'(Fault), 64'd1);
        check("mis_hold_code", 64'(FaultCode), 64'd1);
        BranchTaken = 1'b1; BranchTarget = 64'h0;
        step();
        check("clr_fault", 64'(Fault), 64'd0);
        check("clr_code", 64'(FaultCode), 64'd0);
        check("clr_valid", 64'(InstrValid), 64'd0);
        BranchTaken = 1'b0;
        step(); expect_fetch("after_clr", 64'h0, 32'h03020100);

        // Top of memory, then out-of-range fault at 0x40.
        BranchTaken = 1'b1; BranchTarget = 64'h38;
        step();
        BranchTaken = 1'b0;
        step(); expect_fetch("top38", 64'h38, 32'h3B3A3938);
        step(); expect_fetch("top3c", 64'h3C, 32'h3F3E3D3C);
        step();
        check("oor_fault", 64'(Fault), 64'd1);
        check("oor_code", 64'(FaultCode), 64'd2);
        check("oor_valid", 64'(InstrValid), 64'd0);

        // Write during the fetch of the same word: old data first, new data on refetch.
        BranchTaken = 1'b1; BranchTarget = 64'h8;
        step();
        check("oor_clr", 64'(Fault), 64'd0);
        BranchTaken = 1'b0;
        step(); expect_fetch("w8", 64'h8, 32'h0B0A0908);
        step(); expect_fetch("wc", 64'hC, 32'h0F0E0D0C);
        WrEn = 1'b1; WrAddr = 64'h10; WrData = 32'hDEADBEEF;
        step(); expect_fetch("w_old", 64'h10, 32'h13121110);
        // Ignored writes: misaligned, then beyond the end (must not alias to word 0).
        WrAddr = 64'h15; WrData = 32'h11223344;
        step(); expect_fetch("w14", 64'h14, 32'h17161514);
        WrAddr = 64'h40; WrData = 32'hAAAAAAAA;
        step(); expect_fetch("w18", 64'h18, 32'h1B1A1918);
        WrEn = 1'b0;
        BranchTaken = 1'b1; BranchTarget = 64'h10;
        step();
        BranchTaken = 1'b0;
        step(); expect_fetch("w_new", 64'h10, 32'hDEADBEEF);
        step(); expect_fetch("w_mis_ign", 64'h14, 32'h17161514);
        BranchTaken = 1'b1; BranchTarget = 64'h0;
        step();
        BranchTaken = 1'b0;
        step(); expect_fetch("w_oor_ign", 64'h0, 32'h03020100);
        step(); expect_fetch("pre_rst", 64'h4, 32'h07060504);

        // Asynchronous reset mid-run clears outputs before any edge.
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_instr", 64'(Instruction), 64'd0);
        check("arst_pc", InstrPC, 64'd0);
        check("arst_valid", 64'(InstrValid), 64'd0);
        check("arst_fault", 64'(Fault), 64'd0);
        // A write sampled while reset is low is dropped.
        WrEn = 1'b1; WrAddr = 64'h0; WrData = 32'h55555555;
        step();
        WrEn = 1'b0;
        reset_n = 1'b1;
        step();
        check("rel_idle", 64'(InstrValid), 64'd0);
        step(); expect_fetch("rst_wr_drop", 64'h0, 32'h03020100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Parametrised, registered successor to the combinational instruction memory. It is a byte-addressed, little-endian instruction store with a word write port for program loading, plus an internal next-PC register. Each cycle it fetches sequentially, stalls, or redirects on a branch, and reports misaligned and out-of-range fetches as faults. It sits at the head of the core pipeline and feeds the decode stage.

## Interface
- ADDR_WIDTH, 64, width of every address and PC.
- INSTR_WIDTH, 32, instruction width; fixed at 4 bytes.
- DEPTH_BYTES, 64, memory size in bytes; must be a multiple of 4.
- RESET_PC, 0, first fetch address after reset.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Stall  in  1  hold the fetch state and all outputs this cycle.
- BranchTaken  in  1  redirect fetch to BranchTarget.
- BranchTarget  in  ADDR_WIDTH  redirect address.
- WrEn  in  1  program-load write strobe.
- WrAddr  in  ADDR_WIDTH  word-aligned write byte address.
- WrData  in  INSTR_WIDTH  write data, stored little-endian.
- Instruction  out  INSTR_WIDTH  fetched instruction, registered.
- InstrPC  out  ADDR_WIDTH  address of Instruction.
- InstrValid  out  1  Instruction/InstrPC are meaningful.
- Fault  out  1  fetch fault is pending.
- FaultCode  out  2  fault cause: 00 none, 01 misaligned, 10 out of range.

## Operation
- Storage is a byte array mem[0..DEPTH_BYTES-1]. At time zero each byte is initialised to mem[i] = i mod 256. Reset does not alter contents.
- A read at address a returns {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
- A write at edge with WrEn=1 stores WrData[7:0] to mem[WrAddr], up to WrData[31:24] to mem[WrAddr+3].
- Writes with WrAddr[1:0]≠0 or WrAddr>DEPTH_BYTES-4 are ignored.
- Writes are independent of the FSM and are accepted in every state.
- Internal register NPC (ADDR_WIDTH bits) holds the next fetch address.
- A fetch is bad when NPC[1:0]≠0, giving code 01. It is also bad when NPC>DEPTH_BYTES-4, giving code 10. Misaligned takes priority over out of range.
- FSM states are IDLE, RUN and FAULT.
- IDLE: entered on reset. The next edge moves unconditionally to RUN; no fetch occurs in IDLE.
- RUN, evaluated at each edge in this priority order:
  - BranchTaken: NPC←BranchTarget, InstrValid←0 (bubble), stay in RUN.
  - Stall: NPC and all outputs hold.
  - Bad fetch: InstrValid←0, Fault←1, FaultCode←cause, NPC holds, go to FAULT.
  - Otherwise: Instruction←mem[NPC], InstrPC←NPC, InstrValid←1, NPC←NPC+4.
- FAULT:
  - Outputs hold, with InstrValid=0.
  - Stall is ignored.
  - BranchTaken: NPC←BranchTarget, Fault←0, FaultCode←00, InstrValid←0, go to RUN.
- BranchTaken together with Stall: the branch wins.
- NPC+4 wraps modulo 2^ADDR_WIDTH; the range check faults before any wrap can be fetched.

## Timing
- Reset values while reset_n=0, applied immediately (asynchronous):
  - Instruction=0, InstrPC=0, InstrValid=0, Fault=0, FaultCode=00.
  - NPC=RESET_PC, state=IDLE.
- Reset asserted mid-operation clears the state and outputs at once. A write in flight on that edge is dropped.
- Reset release: edge 1 moves IDLE→RUN. Edge 2 presents mem[RESET_PC] with InstrValid=1.
- Sequential fetch latency: address present in NPC at edge k → instruction visible after edge k.
- Steady-state throughput is one instruction per cycle.
- Branch sampled at edge k: a bubble (InstrValid=0) is visible after edge k, and the target instruction after edge k+1.
- Stall is sampled per edge. Deasserting it resumes with the held NPC at the next edge, with no lost or duplicated instruction.
- Fault is visible after the edge that detected it. It stays asserted until the edge that samples BranchTaken=1.
- Write and fetch of the same word at the same edge: the fetch returns the old contents; the new data is visible from the following edge.

## Test plan
- Reset, release, no stall/branch → edges 2–5 give InstrPC 0, 4, 8, 12 with Instruction 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, and InstrValid=1 throughout.
- Stall=1 for 3 cycles while showing PC 4 → Instruction holds 0x07060504. After release the next output is PC 8, 0x0B0A0908.
- BranchTaken=1 with BranchTarget=0x20, Stall=1 at the same edge → bubble, then InstrPC=0x20 with Instruction=0x23222120, then 0x27262524.
- Branch to 0x22 → Fault=1, FaultCode=01, InstrValid=0, held through Stall pulses. Branch to 0x0 → Fault clears and 0x03020100 follows.
- Branch to 0x38 with DEPTH_BYTES=64 → 0x3B3A3938, then 0x3F3E3D3C, then FaultCode=10 at NPC=0x40.
- Write WrAddr=0x10, WrData=0xDEADBEEF on the same edge that fetches 0x10 → returns 0x13121110. A refetch of 0x10 returns 0xDEADBEEF. Asserting reset_n=0 mid-run clears all outputs to 0 immediately.
